// File: rtl/heater_sequencer.sv
// heater_sequencer: paces the heater control loop (sensor -> PID -> duty) and forces duty to zero on disable or fault
module heater_sequencer #(
  parameter int SAMPLE_PERIOD = 27000000,
  parameter int CONV_TIMEOUT = 24300000,
  parameter int PID_TIMEOUT = 1024,
  parameter int FAULT_LIMIT = 3,
  parameter logic signed [15:0] OVERTEMP = 16'sh05A0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        conv_start,
  input  logic        temp_valid,
  input  logic [15:0] temperature,
  output logic [11:0] meas_out,
  output logic        pid_start,
  input  logic        pid_done,
  input  logic [11:0] pid_response,
  output logic [11:0] duty,
  output logic        duty_load,
  output logic        fault,
  output logic [1:0]  fault_code,
  input  logic        fault_clr,
  output logic        busy
);
  localparam int TMAX = CONV_TIMEOUT > PID_TIMEOUT ? CONV_TIMEOUT : PID_TIMEOUT;
  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam int TW = $clog2(TMAX + 1);
  localparam int MW = $clog2(FAULT_LIMIT + 1);
  typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_COMPUTE, S_APPLY, S_WAIT, S_FAULT} state_t;
  state_t state;
  logic [PW-1:0] per_cnt;
  logic [TW-1:0] tmr;
  logic [MW-1:0] miss;
  logic pend;
  logic tick, trip, lost, hang, flt, stop, go;
  logic [11:0] clip;
  assign tick = per_cnt == PW'(SAMPLE_PERIOD - 1);
  assign trip = state == S_CONVERT && temp_valid && $signed(temperature) >= OVERTEMP;
  assign lost = state == S_CONVERT && !temp_valid && tmr == TW'(CONV_TIMEOUT - 1) && miss == MW'(FAULT_LIMIT - 1);
  assign hang = state == S_COMPUTE && !pid_done && tmr == TW'(PID_TIMEOUT - 1);
  assign flt = trip | lost | hang;
  assign stop = !enable && state inside {S_CONVERT, S_COMPUTE, S_APPLY, S_WAIT} && !flt;
  assign go = enable && (state == S_IDLE || (state inside {S_APPLY, S_WAIT} && (pend || tick)));
  assign clip = temperature[15] ? 12'd0 : |temperature[14:12] ? 12'hFFF : temperature[11:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      per_cnt <= '0;
      tmr <= '0;
      miss <= '0;
      pend <= 1'b0;
      conv_start <= 1'b0;
      meas_out <= '0;
      pid_start <= 1'b0;
      duty <= '0;
      duty_load <= 1'b0;
      fault <= 1'b0;
      fault_code <= '0;
      busy <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      pid_start <= 1'b0;
      duty_load <= 1'b0;
      per_cnt <= tick ? '0 : per_cnt + 1'b1;
      tmr <= tmr + 1'b1;
      if (tick && state inside {S_CONVERT, S_COMPUTE, S_APPLY}) pend <= 1'b1;
      if (flt) begin
        state <= S_FAULT;
        fault <= 1'b1;
        fault_code <= trip ? 2'b10 : lost ? 2'b01 : 2'b11;
        duty <= '0;
        duty_load <= 1'b1;
        busy <= 1'b0;
        pend <= 1'b0;
      end else if (stop) begin
        state <= S_IDLE;
        duty <= '0;
        duty_load <= 1'b1;
        busy <= 1'b0;
        pend <= 1'b0;
      end else if (go) begin
        state <= S_CONVERT;
        conv_start <= 1'b1;
        per_cnt <= '0;
        tmr <= '0;
        pend <= 1'b0;
        busy <= 1'b1;
      end else begin
        case (state)
          S_CONVERT:
            if (temp_valid) begin
              state <= S_COMPUTE;
              miss <= '0;
              meas_out <= clip;
              pid_start <= 1'b1;
              tmr <= '0;
            end else if (tmr == TW'(CONV_TIMEOUT - 1)) begin
              state <= S_WAIT;
              miss <= miss + 1'b1;
              duty <= '0;
              duty_load <= 1'b1;
              busy <= 1'b0;
            end
          S_COMPUTE:
            if (pid_done) begin
              state <= S_APPLY;
              duty <= pid_response;
              duty_load <= 1'b1;
              busy <= 1'b0;
            end
          S_APPLY: state <= S_WAIT;
          S_FAULT:
            if (fault_clr) begin
              state <= S_IDLE;
              fault <= 1'b0;
              fault_code <= '0;
              miss <= '0;
            end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_heater_sequencer.sv
// tb_heater_sequencer: randomized control-loop transactions checked against timing/value expectations derived from the loop rules
module tb_heater_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, temp_valid = 1'b0, pid_done = 1'b0, fault_clr = 1'b0;
  logic [15:0] temperature = '0;
  logic [11:0] pid_response = '0;
  logic conv_start, pid_start, duty_load, fault, busy;
  logic [11:0] meas_out, duty;
  logic [1:0] fault_code;
  logic conv_start2, pid_start2, duty_load2, fault2, busy2;
  logic [11:0] meas_out2, duty2;
  logic [1:0] fault_code2;
  int cyc = 0, n_tests = 0, n_fail = 0, exp_cs = -1;
  localparam int CS = 0, PS = 1, DL = 2, CS2 = 3, DL2 = 4;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  heater_sequencer #(.SAMPLE_PERIOD(100), .CONV_TIMEOUT(40), .PID_TIMEOUT(16), .FAULT_LIMIT(3), .OVERTEMP(16'sh05A0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .conv_start(conv_start), .temp_valid(temp_valid),
    .temperature(temperature), .meas_out(meas_out), .pid_start(pid_start), .pid_done(pid_done),
    .pid_response(pid_response), .duty(duty), .duty_load(duty_load), .fault(fault),
    .fault_code(fault_code), .fault_clr(fault_clr), .busy(busy));
  heater_sequencer #(.SAMPLE_PERIOD(20), .CONV_TIMEOUT(40), .PID_TIMEOUT(16), .FAULT_LIMIT(3), .OVERTEMP(16'sh05A0)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .conv_start(conv_start2), .temp_valid(temp_valid),
    .temperature(temperature), .meas_out(meas_out2), .pid_start(pid_start2), .pid_done(pid_done),
    .pid_response(pid_response), .duty(duty2), .duty_load(duty_load2), .fault(fault2),
    .fault_code(fault_code2), .fault_clr(fault_clr), .busy(busy2));
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic bit sel(input int s);
    return s == CS ? conv_start : s == PS ? pid_start : s == DL ? duty_load : s == CS2 ? conv_start2 : duty_load2;
  endfunction
  function automatic int clip(input int t);
    return t < 0 ? 0 : t > 4095 ? 4095 : t;
  endfunction
  function automatic int outs1();
    return int'({conv_start, meas_out, pid_start, duty, duty_load, fault, fault_code, busy});
  endfunction
  function automatic int outs2();
    return int'({conv_start2, meas_out2, pid_start2, duty2, duty_load2, fault2, fault_code2, busy2});
  endfunction
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_ev(input int s, input int lim, output int t);
    t = -1;
    for (int i = 0; i <= lim; i++) begin
      if (sel(s)) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic pulse_tv(input int t);
    temp_valid = 1'b1;
    temperature = 16'(t);
    @(negedge clk);
    temp_valid = 1'b0;
  endtask
  task automatic pulse_done(input int r);
    pid_done = 1'b1;
    pid_response = 12'(r);
    @(negedge clk);
    pid_done = 1'b0;
  endtask
  task automatic start_cycle(output int c);
    wait_ev(CS, 200, c);
    if (exp_cs >= 0) check("cs_time", c, exp_cs);
    check("busy_conv", int'(busy), 1);
    exp_cs = c + 100;
  endtask
  task automatic run_cycle(input int dv, input int t, input int dp, input int r);
    int c, p, a;
    start_cycle(c);
    step(dv);
    pulse_tv(t);
    wait_ev(PS, 2, p);
    check("ps_time", p, c + dv + 1);
    check("meas", int'(meas_out), clip(t));
    step(dp);
    pulse_done(r);
    wait_ev(DL, 2, a);
    check("dl_time", a, p + dp + 1);
    check("duty", int'(duty), r);
    step(1);
    check("dl_width", int'(duty_load), 0);
  endtask
  task automatic rand_cycle();
    run_cycle(int'($urandom_range(1, 39)), int'($urandom_range(0, 1939)) - 500,
              int'($urandom_range(1, 15)), int'($urandom_range(0, 4095)));
  endtask
  task automatic clear_fault();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("clr_fault", int'(fault), 0);
    check("clr_code", int'(fault_code), 0);
    check("clr_idle", int'(conv_start), 0);
    step(1);
    check("clr_cs", int'(conv_start), 1);
    exp_cs = cyc;
  endtask
  task automatic miss_cycle(input int f, input int code);
    int c, a;
    start_cycle(c);
    wait_ev(DL, 60, a);
    check("miss_dl_time", a, c + 40);
    check("miss_duty", int'(duty), 0);
    check("miss_fault", int'(fault), f);
    check("miss_code", int'(fault_code), code);
    check("miss_busy", int'(busy), 0);
  endtask
  task automatic trip(input int t);
    int c, k;
    start_cycle(c);
    step(3);
    pulse_tv(t);
    check("trip_dl", int'(duty_load), 1);
    check("trip_duty", int'(duty), 0);
    check("trip_fault", int'(fault), 1);
    check("trip_code", int'(fault_code), 2);
    check("trip_no_ps", int'(pid_start), 0);
    pulse_tv(100);
    pulse_done(5);
    wait_ev(CS, 120, k);
    check("fault_hold_cs", k, -1);
    check("fault_hold", int'(fault), 1);
    clear_fault();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int c, p, a, k, seen;
    step(3);
    check("rst_outs", outs1(), 0);
    rst_n = 1'b1;
    step(2);
    check("idle_no_cs", int'(conv_start), 0);
    enable = 1'b1;
    step(1);
    check("en_cs", int'(conv_start), 1);
    exp_cs = cyc;
    run_cycle(10, 'h320, 5, 'h7FF);
    run_cycle(5, -128, 3, 100);
    run_cycle(8, 1439, 15, 'hABC);
    for (int i = 0; i < 6; i++) rand_cycle();
    trip('h5A0);
    trip(int'($urandom_range(1441, 32767)));
    miss_cycle(0, 0);
    miss_cycle(0, 0);
    rand_cycle();
    miss_cycle(0, 0);
    miss_cycle(0, 0);
    miss_cycle(1, 1);
    clear_fault();
    start_cycle(c);
    step(4);
    pulse_tv(200);
    wait_ev(PS, 2, p);
    wait_ev(DL, 30, a);
    check("hang_time", a, p + 16);
    check("hang_code", int'(fault_code), 3);
    check("hang_fault", int'(fault), 1);
    check("hang_duty", int'(duty), 0);
    clear_fault();
    rand_cycle();
    start_cycle(c);
    step(6);
    pulse_tv(300);
    wait_ev(PS, 2, p);
    step(3);
    enable = 1'b0;
    step(1);
    check("dis_dl", int'(duty_load), 1);
    check("dis_duty", int'(duty), 0);
    check("dis_busy", int'(busy), 0);
    pulse_done(9);
    wait_ev(DL, 10, a);
    check("dis_late_done", a, -1);
    enable = 1'b1;
    step(1);
    check("reen_cs", int'(conv_start), 1);
    exp_cs = cyc;
    rand_cycle();
    start_cycle(c);
    step(4);
    pulse_tv(1000);
    wait_ev(PS, 2, p);
    step(2);
    rst_n = 1'b0;
    #1;
    check("rst_async", outs1(), 0);
    check("rst_async2", outs2(), 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= int'(conv_start | pid_start | duty_load | busy);
    end
    check("rst_quiet", seen, 0);
    check("rst_duty", int'(duty), 0);
    rst_n = 1'b1;
    step(1);
    check("rst_cs", int'(conv_start), 1);
    check("rst_cs2", int'(conv_start2), 1);
    c = cyc;
    step(5);
    pulse_tv(500);
    step(14);
    pulse_done('h123);
    wait_ev(DL2, 3, a);
    check("ovr_apply", a, c + 21);
    check("ovr_duty", int'(duty2), 'h123);
    wait_ev(CS2, 5, k);
    check("ovr_cs", k, a + 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
